dsp_int8_packed_mac: RTL and testbench
======================================

# dsp_int8_packed_mac

Parametrised two-lane int8 multiply-accumulate. Two signed weights share one signed activation and are packed into a single wide multiplier operand, so one DSP multiplier computes both products. Packed products are accumulated over a variable-length group ended by `in_last`; the two lane sums are then split apart with sign-borrow correction. The block sits in the CNN datapath between the weight/activation fetch logic and the requantisation stage. It is the accumulating, handshaked, width-generic successor of `dsp_int8_packing`.

## Interface
Parameters:
- `DATA_W`, 8, width of signed operands a, b, c
- `MAX_LEN`, 256, maximum beats per accumulation group (power of two, ≥2)
- `ACC_W`, 2*DATA_W+$clog2(MAX_LEN), lane accumulator/output width (derived; do not override)

Ports:
- `clk`  in  1  clock; all logic rising-edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  block can accept a beat
- `in_last`  in  1  beat closes the current group
- `in_a`  in  DATA_W  signed weight, lane A (high lane)
- `in_b`  in  DATA_W  signed weight, lane B (low lane)
- `in_c`  in  DATA_W  signed shared activation
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_ac`  out  ACC_W  signed Σ a·c for the group
- `out_bc`  out  ACC_W  signed Σ b·c for the group
- `out_count`  out  $clog2(MAX_LEN)+1  beats in the group
- `out_ovf`  out  1  group exceeded MAX_LEN beats

## Operation
- Packing: `packed = (sext(a) <<< ACC_W) + sext(b)`; `prod = packed * sext(c)`, which equals `(a·c <<< ACC_W) + b·c` exactly.
- Accumulation is done in the packed domain: `acc = first ? prod : acc + prod`, full width 2*ACC_W+1 bits. `first` is set after reset and after every last beat.
- Extraction on the last beat: `bc = acc[ACC_W-1:0]` read as signed; `ac = acc[2*ACC_W-1:ACC_W] + acc[ACC_W-1]` (borrow correction).
- Beat counter: counts beats in the group. Reported in `out_count`; restarts at 1 on the first beat of a group.
- Overflow: if the count would exceed MAX_LEN, `out_ovf` is set sticky for that group. Lane values then wrap modulo 2^ACC_W and are not guaranteed; the group still completes on `in_last`.
- Handshake: global advance `en = !out_valid || out_ready`; `in_ready = en`. A beat transfers on `in_valid && in_ready`. All pipeline stages advance only on `en`, and bubbles propagate.
- Output holds stable while `out_valid && !out_ready`.
- A group of one beat (`in_last` on its first beat) is legal.
- Back-to-back groups are legal: a new group's first beat may be accepted the cycle after the previous last beat.

## Timing
- Pipeline: S1 input/packing register → S2 multiply register → S3 accumulator → S4 split/output register.
- Latency: a last beat accepted at edge T gives `out_valid` high after edge T+4, provided no stall occurs.
- Throughput is one beat per cycle while `out_ready` is high or the output is empty.
- Reset values: `out_valid`=0, `out_ac`=0, `out_bc`=0, `out_count`=0, `out_ovf`=0. `in_ready`=1 when `rst_n` is high.
- Reset asserted mid-group discards all partial state. The first beat after release starts a fresh group.

## Configuration
- `DSP_PACK_OVF_EN` defined: counter overflow detection is active and `out_ovf` is driven as above.
- `DSP_PACK_OVF_EN` undefined: overflow logic is removed, `out_ovf` is tied to 0, and `out_count` saturates at MAX_LEN.

## Structure
- Shared package `dsp_pack_pkg`: `DATA_W` default, function `acc_w(data_w, max_len)`, typedef for the packed accumulator, extraction function `split_lanes`.
- One sub-module, `dsp_pack_mul`: the S1/S2 packing and registered multiply. It is kept separate so synthesis infers a single DSP and other packed-MAC blocks can reuse it.

## Test plan
- Single beat, a=10, b=5, c=-3, last=1 → out_ac=-30, out_bc=-15, out_count=1, out_valid exactly 4 cycles after acceptance.
- Three-beat group (10,5,-3), (12,4,-2), (1,1,-1) → out_ac=-55, out_bc=-24, out_count=3. Check borrow correction when the low lane is negative.
- Extremes: 256 beats of a=b=c=-128 with MAX_LEN=256 → out_ac=out_bc=4194304, out_ovf=0. A 257th beat before last → out_ovf=1.
- Backpressure: hold out_ready=0 with a result pending → in_ready=0, outputs stable. Release → next group's result appears intact, with no beat lost or duplicated.
- Reset mid-group: 2 beats, then rst_n low for 1 cycle, then a single beat (17,98,-63,last) → out_ac=-1071, out_bc=-6174, out_count=1.
- Back-to-back one-beat groups with in_valid held high → one result per cycle, each matching a golden model.

Source files
------------

// File: rtl/dsp_pack_pkg.sv
// dsp_pack_pkg: default widths, packed accumulator type and lane extraction shared by packed-MAC blocks
package dsp_pack_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int MAX_LEN_DEF = 256;
  localparam int MAX_ACC_W = 64;
  localparam int PACC_W = 2 * MAX_ACC_W + 1;
  typedef logic signed [PACC_W-1:0] pacc_t;
  typedef struct packed {
    logic signed [MAX_ACC_W-1:0] ac;
    logic signed [MAX_ACC_W-1:0] bc;
  } lanes_t;
  function automatic int acc_w(input int data_w, input int max_len);
    return 2 * data_w + $clog2(max_len);
  endfunction
  // The low lane is read as signed; a negative low lane borrowed one from the high lane, so add it back.
  function automatic lanes_t split_lanes(input pacc_t acc, input int aw);
    pacc_t lo, hi;
    lo = (acc <<< (PACC_W - aw)) >>> (PACC_W - aw);
    hi = (acc >>> aw) + {{(PACC_W-1){1'b0}}, acc[aw-1]};
    split_lanes.ac = hi[MAX_ACC_W-1:0];
    split_lanes.bc = lo[MAX_ACC_W-1:0];
  endfunction
endpackage

// File: rtl/dsp_int8_packed_mac_if.sv
// dsp_int8_packed_mac_if: beat input channel and group result channel of the packed MAC
interface dsp_int8_packed_mac_if
  import dsp_pack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int ACC_W = acc_w(DATA_W, MAX_LEN)
);
  localparam int CNT_W = $clog2(MAX_LEN) + 1;
  logic in_valid;
  logic in_ready;
  logic in_last;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic signed [DATA_W-1:0] in_c;
  logic out_valid;
  logic out_ready;
  logic signed [ACC_W-1:0] out_ac;
  logic signed [ACC_W-1:0] out_bc;
  logic [CNT_W-1:0] out_count;
  logic out_ovf;
  modport master (
    output in_valid, in_last, in_a, in_b, in_c, out_ready,
    input in_ready, out_valid, out_ac, out_bc, out_count, out_ovf
  );
  modport slave (
    input in_valid, in_last, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_ac, out_bc, out_count, out_ovf
  );
endinterface

// File: rtl/dsp_pack_mul.sv
// dsp_pack_mul: input register, weight packing register and one registered multiply forming both lane products
module dsp_pack_mul #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 24,
  localparam int PK_W = ACC_W + DATA_W + 1,
  localparam int PROD_W = PK_W + DATA_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic in_valid,
  input  logic in_last,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  output logic out_valid,
  output logic out_last,
  output logic signed [PROD_W-1:0] prod
);
  logic s0_v, s0_l, s1_v, s1_l;
  logic signed [DATA_W-1:0] a_r, b_r, c_r, c_p;
  logic signed [PK_W-1:0] packed_op;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s0_v <= 1'b0;
      s0_l <= 1'b0;
      s1_v <= 1'b0;
      s1_l <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      c_r <= '0;
      c_p <= '0;
      packed_op <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      prod <= '0;
    end else if (en) begin
      s0_v <= in_valid;
      s0_l <= in_last;
      a_r <= a;
      b_r <= b;
      c_r <= c;
      s1_v <= s0_v;
      s1_l <= s0_l;
      c_p <= c_r;
      packed_op <= (PK_W'(a_r) <<< ACC_W) + PK_W'(b_r);
      out_valid <= s1_v;
      out_last <= s1_l;
      prod <= PROD_W'(packed_op) * PROD_W'(c_p);
    end
endmodule

// File: rtl/dsp_int8_packed_mac.sv
// dsp_int8_packed_mac: two-lane int8 MAC accumulating packed products per group, then splitting the lanes.
// Define DSP_PACK_OVF_EN to enable beat-count overflow detection on out_ovf.
module dsp_int8_packed_mac
  import dsp_pack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int ACC_W = acc_w(DATA_W, MAX_LEN)
) (
  input logic clk,
  input logic rst_n,
  dsp_int8_packed_mac_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LEN) + 1;
  localparam int PROD_W = ACC_W + 2 * DATA_W + 1;
  localparam int SUM_W = 2 * ACC_W + 1;
  logic en, p_v, p_l, first, done, ovf, ovf_nxt;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0] acc, sum;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  lanes_t lanes;
  assign en = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;
  dsp_pack_mul #(.DATA_W(DATA_W), .ACC_W(ACC_W)) mul (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .in_valid(bus.in_valid),
    .in_last(bus.in_last),
    .a(bus.in_a),
    .b(bus.in_b),
    .c(bus.in_c),
    .out_valid(p_v),
    .out_last(p_l),
    .prod(prod)
  );
  assign sum = first ? SUM_W'(prod) : acc + SUM_W'(prod);
  assign cnt_nxt = first ? CNT_W'(1) : (cnt == CNT_W'(MAX_LEN) ? cnt : cnt + CNT_W'(1));
`ifdef DSP_PACK_OVF_EN
  assign ovf_nxt = !first && (ovf || cnt == CNT_W'(MAX_LEN));
`else
  assign ovf_nxt = 1'b0;
`endif
  assign lanes = split_lanes(pacc_t'(acc), ACC_W);
  // S4 samples acc at the edge after the closing beat, before a following group overwrites it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      first <= 1'b1;
      done <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_ac <= '0;
      bus.out_bc <= '0;
      bus.out_count <= '0;
      bus.out_ovf <= 1'b0;
    end else if (en) begin
      if (p_v) begin
        acc <= sum;
        cnt <= cnt_nxt;
        ovf <= ovf_nxt;
        first <= p_l;
      end
      done <= p_v && p_l;
      bus.out_valid <= done;
      if (done) begin
        bus.out_ac <= ACC_W'(lanes.ac);
        bus.out_bc <= ACC_W'(lanes.bc);
        bus.out_count <= cnt;
        bus.out_ovf <= ovf;
      end
    end
endmodule

// File: tb/tb_dsp_int8_packed_mac.sv
// tb_dsp_int8_packed_mac: directed and randomized groups checked against per-lane sum-of-products arithmetic
`timescale 1ns/1ps
module tb_dsp_int8_packed_mac;
  localparam int DW = 8;
  localparam int ML = 256;
  localparam int AW = 2 * DW + $clog2(ML);
  localparam int CW = $clog2(ML) + 1;
  typedef struct {
    logic signed [AW-1:0] ac;
    logic signed [AW-1:0] bc;
    int cnt;
    bit ovf;
    bit lanes;
  } res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  dsp_int8_packed_mac_if #(.DATA_W(DW), .MAX_LEN(ML)) bus();
  dsp_int8_packed_mac #(.DATA_W(DW), .MAX_LEN(ML)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  int total = 0;
  int bad = 0;
  int seen = 0;
  int m_ac = 0, m_bc = 0, m_n = 0;
  bit rnd_bp = 0;
  res_t exp_q[$];
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  function automatic int rs();
    return int'($urandom_range(0, 255)) - 128;
  endfunction
  task automatic model(input int a, input int b, input int c, input bit last);
    res_t e;
    m_ac += a * c;
    m_bc += b * c;
    m_n++;
    if (last) begin
      e.ac = AW'(m_ac);
      e.bc = AW'(m_bc);
      e.cnt = m_n > ML ? ML : m_n;
`ifdef DSP_PACK_OVF_EN
      e.ovf = m_n > ML;
`else
      e.ovf = 1'b0;
`endif
      e.lanes = m_n <= ML;
      exp_q.push_back(e);
      m_ac = 0;
      m_bc = 0;
      m_n = 0;
    end
  endtask
  task automatic send(input int a, input int b, input int c, input bit last, output int cyc);
    bit ok;
    ok = 1'b0;
    cyc = 0;
    bus.in_a = DW'(a);
    bus.in_b = DW'(b);
    bus.in_c = DW'(c);
    bus.in_last = last;
    bus.in_valid = 1'b1;
    while (!ok && cyc < 1000) begin
      if (rnd_bp) bus.out_ready = $urandom_range(0, 3) != 0;
      #1;
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("send_accepted", ok, 1);
    if (ok) model(a, b, c, last);
  endtask
  task automatic wait_valid(input string tag);
    for (int k = 0; k < 50 && !bus.out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    chk(tag, bus.out_valid, 1);
  endtask
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) begin
      res_t e;
      seen++;
      chk("result_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.lanes) begin
          chk("model_ac", bus.out_ac, e.ac);
          chk("model_bc", bus.out_bc, e.bc);
        end
        chk("model_count", bus.out_count, e.cnt);
        chk("model_ovf", bus.out_ovf, e.ovf);
      end
    end
  initial begin
    int cyc, s0, ra, rb, rc, n;
    logic signed [AW-1:0] h_ac, h_bc;
    logic [CW-1:0] h_cnt;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_c = '0;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_ac", bus.out_ac, 0);
    chk("rst_out_bc", bus.out_bc, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_ovf", bus.out_ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    send(10, 5, -3, 1, cyc);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("latency_valid_%0d", k), bus.out_valid, k == 4);
    end
    chk("single_ac", bus.out_ac, -30);
    chk("single_bc", bus.out_bc, -15);
    chk("single_count", bus.out_count, 1);
    repeat (3) @(posedge clk);
    #1;
    send(10, 5, -3, 0, cyc);
    send(12, 4, -2, 0, cyc);
    send(1, 1, -1, 1, cyc);
    bus.in_valid = 1'b0;
    wait_valid("three_valid");
    chk("three_ac", bus.out_ac, -55);
    chk("three_bc", bus.out_bc, -24);
    chk("three_count", bus.out_count, 3);
    for (int i = 0; i < 256; i++) send(-128, -128, -128, i == 255, cyc);
    bus.in_valid = 1'b0;
    wait_valid("ext256_valid");
    chk("ext256_ac", bus.out_ac, 4194304);
    chk("ext256_bc", bus.out_bc, 4194304);
    chk("ext256_count", bus.out_count, 256);
    chk("ext256_ovf", bus.out_ovf, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 257; i++) send(-128, -128, -128, i == 256, cyc);
    bus.in_valid = 1'b0;
    wait_valid("ext257_valid");
`ifdef DSP_PACK_OVF_EN
    chk("ext257_ovf", bus.out_ovf, 1);
`else
    chk("ext257_ovf", bus.out_ovf, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(rs(), rs(), rs(), 0, cyc);
    send(rs(), rs(), rs(), 1, cyc);
    bus.in_valid = 1'b0;
    wait_valid("bp_valid");
    h_ac = bus.out_ac;
    h_bc = bus.out_bc;
    h_cnt = bus.out_count;
    ra = rs();
    rb = rs();
    rc = rs();
    bus.in_a = DW'(ra);
    bus.in_b = DW'(rb);
    bus.in_c = DW'(rc);
    bus.in_last = 1'b1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_ac", bus.out_ac, h_ac);
      chk("bp_hold_bc", bus.out_bc, h_bc);
      chk("bp_hold_count", bus.out_count, h_cnt);
    end
    bus.out_ready = 1'b1;
    send(ra, rb, rc, 1, cyc);
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_drained", exp_q.size(), 0);
    send(rs(), rs(), rs(), 0, cyc);
    send(rs(), rs(), rs(), 0, cyc);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    m_ac = 0;
    m_bc = 0;
    m_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(17, 98, -63, 1, cyc);
    bus.in_valid = 1'b0;
    wait_valid("rst_mid_valid");
    chk("rst_mid_ac", bus.out_ac, -1071);
    chk("rst_mid_bc", bus.out_bc, -6174);
    chk("rst_mid_count", bus.out_count, 1);
    repeat (3) @(posedge clk);
    #1;
    s0 = seen;
    for (int i = 0; i < 20; i++) begin
      send(rs(), rs(), rs(), 1, cyc);
      chk("b2b_one_cycle", cyc, 1);
    end
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_results", seen - s0, 20);
    rnd_bp = 1'b1;
    for (int g = 0; g < 40; g++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) send(rs(), rs(), rs(), i == n - 1, cyc);
      if ($urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    rnd_bp = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
